// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-game round sequencer.
// Contents: FSM state encodings, LFSR geometry and default seed, and the
// target-to-LED one-hot mapping.
package reaction_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_GAP  = 2'd1;
   localparam logic [1:0] ST_SHOW = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // x^7 + x^6 + 1: feedback taps are q[6] and q[5], new bit enters at q[0].
   localparam int LFSR_W      = 7;
   localparam int LFSR_TAP_HI = 6;
   localparam int LFSR_TAP_LO = 5;
   localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 7'h01;

   // Three LEDs but four LFSR codes: code 2'b11 folds onto target 0.
   function automatic logic [2:0] target_onehot(input logic [1:0] code);
      logic [2:0] oh;
      case (code)
         2'd0:    oh = 3'b001;
         2'd1:    oh = 3'b010;
         2'd2:    oh = 3'b100;
         default: oh = 3'b001;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for already-synchronised button levels.
// Ports:
//   clk    in      system clock
//   rst_n  in      async active-low reset
//   btn    in  W   button levels
//   press  out W   high for the cycle in which a button goes 0->1
module btn_edge_detect #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] btn,
   output logic [WIDTH-1:0] press
);

   logic [WIDTH-1:0] btn_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_q <= '0;
      end else begin
         btn_q <= btn;
      end
   end

   assign press = btn & ~btn_q;

endmodule

// File: rtl/reaction_round_ctrl.sv
// Round sequencer for the three-button reaction game: free-running LFSR
// target generator, per-round dark gap and lit window, first-press judging,
// round/hit counting and game-over.
// Ports:
//   clk    in      system clock
//   rst_n  in      async active-low reset
//   start  in      game start request (accepted only in IDLE/DONE)
//   btn    in  3   synchronised button levels
//   led    out 3   one-hot target, non-zero only in SHOW
//   hit    out     one-cycle pulse, correct press
//   miss   out     one-cycle pulse, wrong press or window timeout
//   score  out 4   hits in current/last game
//   busy   out     in GAP or SHOW
//   done   out     in DONE
//
// state | meaning
// IDLE  | after reset, waiting for start
// GAP   | dark interval before a target, presses ignored
// SHOW  | target lit, waiting for first press or timeout
// DONE  | all rounds played, score held until next start
module reaction_round_ctrl
   import reaction_pkg::*;
#(
   parameter int                WINDOW_CYCLES = 8,
   parameter int                GAP_CYCLES    = 4,
   parameter int                ROUNDS        = 15,
   parameter logic [LFSR_W-1:0] LFSR_SEED     = LFSR_SEED_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] btn,
   output logic [2:0] led,
   output logic       hit,
   output logic       miss,
   output logic [3:0] score,
   output logic       busy,
   output logic       done
);

   localparam int TMR_MAX = (WINDOW_CYCLES > GAP_CYCLES) ? WINDOW_CYCLES : GAP_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
   localparam logic [TMR_W-1:0] WIN_LOAD = TMR_W'(WINDOW_CYCLES - 1);
   localparam logic [3:0]       ROUNDS_C = 4'(ROUNDS);

   logic [1:0]        state;
   logic [LFSR_W-1:0] lfsr;
   logic [TMR_W-1:0]  tmr;
   logic [3:0]        round_cnt;
   logic [3:0]        round_nxt;
   logic [2:0]        press;

   btn_edge_detect #(.WIDTH(3)) u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn),
      .press (press)
   );

   assign round_nxt = round_cnt + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         lfsr      <= LFSR_SEED;
         tmr       <= '0;
         round_cnt <= '0;
         led       <= '0;
         hit       <= 1'b0;
         miss      <= 1'b0;
         score     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO]};
         hit  <= 1'b0;
         miss <= 1'b0;

         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  score     <= '0;
                  round_cnt <= '0;
                  tmr       <= GAP_LOAD;
                  state     <= ST_GAP;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end

            ST_GAP: begin
               if (tmr == '0) begin
                  led   <= target_onehot(lfsr[1:0]);
                  tmr   <= WIN_LOAD;
                  state <= ST_SHOW;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end

            ST_SHOW: begin
               // A press seen on the final window cycle wins over the timeout.
               if ((press != '0) || (tmr == '0)) begin
                  // led holds the latched target for the whole of SHOW.
                  if ((press != '0) && (press == led)) begin
                     hit   <= 1'b1;
                     score <= score + 4'd1;
                  end else begin
                     miss <= 1'b1;
                  end
                  led       <= '0;
                  round_cnt <= round_nxt;
                  if (round_nxt == ROUNDS_C) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     tmr   <= GAP_LOAD;
                     state <= ST_GAP;
                  end
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end

            default: begin
               state <= ST_IDLE;
               led   <= '0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reaction_round_ctrl.sv
module tb_reaction_round_ctrl;

   localparam int WIN = 8;
   localparam int GAP = 4;
   localparam int RND = 2;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] btn   = 3'b000;
   logic [2:0] led;
   logic       hit, miss, busy, done;
   logic [3:0] score;
   logic [12:0] obs;

   typedef struct {
      string       name;
      logic [12:0] v;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   int         errors = 0;
   int         checks = 0;
   logic [2:0] tgt;
   logic [6:0] lfsr_m;

   always #5 clk = ~clk;

   reaction_round_ctrl #(
      .WINDOW_CYCLES (WIN),
      .GAP_CYCLES    (GAP),
      .ROUNDS        (RND),
      .LFSR_SEED     (7'h01)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .btn   (btn),
      .led   (led),
      .hit   (hit),
      .miss  (miss),
      .score (score),
      .busy  (busy),
      .done  (done)
   );

   assign obs = {led, hit, miss, score, busy, done};

   // Reference LFSR: x^7+x^6+1, new bit q6^q5 into q0, seed 7'h01.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_m <= 7'h01;
      else        lfsr_m <= {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
   end

   function automatic logic [12:0] pk(logic [2:0] l, logic h, logic m,
                                      logic [3:0] s, logic b, logic d);
      return {l, h, m, s, b, d};
   endfunction

   function automatic logic [2:0] oh(logic [1:0] t);
      case (t)
         2'd1:    return 3'b010;
         2'd2:    return 3'b100;
         default: return 3'b001;
      endcase
   endfunction

   function automatic logic [2:0] rot(logic [2:0] x);
      return {x[1:0], x[2]};
   endfunction

   function automatic logic [6:0] adv(logic [6:0] v, int n);
      logic [6:0] r;
      r = v;
      for (int i = 0; i < n; i++) r = {r[5:0], r[6] ^ r[5]};
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; btn = 3'b000;
      #1;
      sb.push_back('{"reset_async", pk(3'b000, 0, 0, 4'd0, 0, 0)});
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
      repeat (3) step();
      rst_n = 1'b1;
      sb.push_back('{"reset_idle", pk(3'b000, 0, 0, 4'd0, 0, 0)});
      step();
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
   endtask

   task automatic test_timeout_game();
      logic [2:0] l;
      start = 1'b1;
      sb.push_back('{"timeout_start", pk(3'b000, 0, 0, 4'd0, 1, 0)});
      step();
      start = 1'b0;
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
      for (int k = 1; k <= 24; k++) begin
         if (k == 4 || k == 16) tgt = oh(lfsr_m[1:0]);
         l = ((k >= 4 && k < 12) || (k >= 16 && k < 24)) ? tgt : 3'b000;
         sb.push_back('{"timeout_game", pk(l, 0, (k == 12 || k == 24), 4'd0, (k < 24), (k == 24))});
         step();
         e = sb.pop_front(); checks++;
         if (obs !== e.v) begin errors++; $display("FAIL %s k=%0d got=%b want=%b", e.name, k, obs, e.v); end
      end
   endtask

   task automatic test_correct_then_wrong();
      logic [2:0] l;
      start = 1'b1;
      sb.push_back('{"correct_start", pk(3'b000, 0, 0, 4'd0, 1, 0)});
      step();
      start = 1'b0;
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
      for (int k = 1; k <= 14; k++) begin
         if (k == 4 || k == 11) tgt = oh(lfsr_m[1:0]);
         if (k == 7)  btn = tgt;
         if (k == 8)  btn = 3'b000;
         if (k == 13) btn = rot(tgt);
         if (k == 14) btn = 3'b000;
         l = ((k >= 4 && k < 7) || (k >= 11 && k < 13)) ? tgt : 3'b000;
         sb.push_back('{"correct_wrong", pk(l, (k == 7), (k == 13), (k >= 7) ? 4'd1 : 4'd0,
                                             (k < 13), (k >= 13))});
         step();
         e = sb.pop_front(); checks++;
         if (obs !== e.v) begin errors++; $display("FAIL %s k=%0d got=%b want=%b", e.name, k, obs, e.v); end
      end
   endtask

   task automatic test_combo_and_held();
      logic [2:0] l;
      logic [2:0] t1;
      start = 1'b1;
      sb.push_back('{"combo_start_clears", pk(3'b000, 0, 0, 4'd0, 1, 0)});
      step();
      start = 1'b0;
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
      t1 = 3'b000;
      for (int k = 1; k <= 18; k++) begin
         if (k == 4) t1 = oh(lfsr_m[1:0]);
         if (k == 5) btn = t1 | rot(t1);
         if (k == 6) btn = 3'b000;
         if (k == 9) begin
            tgt = oh(lfsr_m[1:0]);
            btn = tgt;
         end
         if (k == 18) btn = 3'b000;
         l = (k == 4) ? t1 : ((k >= 9 && k < 17) ? tgt : 3'b000);
         sb.push_back('{"combo_held", pk(l, 0, (k == 5 || k == 17), 4'd0, (k < 17), (k >= 17))});
         step();
         e = sb.pop_front(); checks++;
         if (obs !== e.v) begin errors++; $display("FAIL %s k=%0d got=%b want=%b", e.name, k, obs, e.v); end
      end
   endtask

   task automatic test_last_cycle_hit_start_held();
      logic [2:0] l;
      start = 1'b1;
      sb.push_back('{"lasthit_start", pk(3'b000, 0, 0, 4'd0, 1, 0)});
      step();
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
      for (int k = 1; k <= 25; k++) begin
         if (k == 4 || k == 16) tgt = oh(lfsr_m[1:0]);
         if (k == 12) btn = tgt;
         if (k == 13) btn = 3'b000;
         if (k == 25) start = 1'b0;
         l = ((k >= 4 && k < 12) || (k >= 16 && k < 24)) ? tgt : 3'b000;
         sb.push_back('{"lasthit_startheld", pk(l, (k == 12), (k == 24), (k >= 12) ? 4'd1 : 4'd0,
                                                 (k < 24), (k >= 24))});
         step();
         e = sb.pop_front(); checks++;
         if (obs !== e.v) begin errors++; $display("FAIL %s k=%0d got=%b want=%b", e.name, k, obs, e.v); end
      end
   endtask

   task automatic test_reset_mid_show();
      int         d;
      logic [6:0] v;
      d = -1;
      for (int i = 0; i < 128; i++) begin
         v = adv(lfsr_m, i + 4);
         if (oh(v[1:0]) == 3'b010) begin
            d = i;
            break;
         end
      end
      checks++;
      if (d < 0) begin
         errors++;
         $display("FAIL reset_find_target got=none want=led 010 within 128 cycles");
         return;
      end
      repeat (d) step();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      sb.push_back('{"reset_show_led", pk(3'b010, 0, 0, 4'd0, 1, 0)});
      step();
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
      rst_n = 1'b0;
      #1;
      sb.push_back('{"reset_mid_show", pk(3'b000, 0, 0, 4'd0, 0, 0)});
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
      sb.push_back('{"reset_held", pk(3'b000, 0, 0, 4'd0, 0, 0)});
      step();
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
      // From seed 7'h01 the code seen at E0+4 is 7'h10, so target 0.
      rst_n = 1'b1;
      start = 1'b1;
      sb.push_back('{"fresh_start", pk(3'b000, 0, 0, 4'd0, 1, 0)});
      step();
      start = 1'b0;
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
      for (int k = 1; k <= 12; k++) begin
         sb.push_back('{"fresh_game", pk((k >= 4 && k < 12) ? 3'b001 : 3'b000, 0, (k == 12), 4'd0, 1, 0)});
         step();
         e = sb.pop_front(); checks++;
         if (obs !== e.v) begin errors++; $display("FAIL %s k=%0d got=%b want=%b", e.name, k, obs, e.v); end
      end
   endtask

   initial begin
      test_reset();
      test_timeout_game();
      test_correct_then_wrong();
      test_combo_and_held();
      test_last_cycle_hit_start_held();
      test_reset_mid_show();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=bench completion");
      $fatal(1);
   end

endmodule

// File: doc/reaction_round_ctrl.md
# reaction_round_ctrl

Round sequencer for the three-button reaction game. It owns the pseudo-random target generator, lights one of three LEDs per round, and judges the first button press in each window. It also counts rounds and hits and signals game-over. It sits between the chip's raw button inputs and the LED/score outputs, and replaces the ad-hoc per-button latch-and-compare logic with a single scheduled FSM.

## Interface
- `WINDOW_CYCLES`, default 8: cycles a target stays lit (≥2).
- `GAP_CYCLES`, default 4: dark cycles before each target (≥1).
- `ROUNDS`, default 15: rounds per game (1..15).
- `LFSR_SEED`, default 7'h01: LFSR reset value (non-zero).
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: game start request, level-sampled, synchronous.
- `btn`  in  3: button levels, already synchronised.
- `led`  out  3: one-hot target display; 0 when not in SHOW.
- `hit`  out  1: one-cycle pulse on a correct press.
- `miss`  out  1: one-cycle pulse on a wrong press or a timeout.
- `score`  out  4: hits in the current or last game.
- `busy`  out  1: high in GAP or SHOW.
- `done`  out  1: high in DONE.

## Operation
- **States:** IDLE, GAP, SHOW, DONE. All outputs are registered.
- **LFSR:**
  - 7-bit Fibonacci, polynomial x^7+x^6+1.
  - New bit = q[6]^q[5], shifted in at q[0].
  - Advances every cycle from reset, independent of state.
- **Target latch:** on the GAP→SHOW edge, target = q[1:0], with 2'b11 mapped to 0. `led` = one-hot(target) throughout SHOW.
- **Press detection:** press = `btn` & ~`btn_q`. `btn_q` is the registered previous `btn` and updates every cycle. Only rising edges count; a held button never counts.
- **IDLE / DONE:**
  - `start`=1 clears `score` and the round counter, then goes to GAP.
  - `start` is ignored while `busy`=1.
- **GAP:** counts `GAP_CYCLES`, then goes to SHOW. Presses in GAP are ignored.
- **SHOW, first cycle with press≠0:**
  - press == one-hot(target) → `hit`, `score`+1.
  - Any other pattern, including target plus another button → `miss`.
  - The round ends immediately.
- **SHOW, no press:** after `WINDOW_CYCLES` cycles → `miss`, round ends.
- **Round end:** round counter +1. Go to DONE if the counter equals `ROUNDS`, otherwise go to GAP.
- **Score:** 4-bit. It cannot overflow because `ROUNDS` ≤ 15.
- **Reset:** asynchronous, effective at any point including mid-round. Values:
  - state = IDLE.
  - LFSR = `LFSR_SEED`.
  - `btn_q` = 0, counters = 0.
  - `led`, `hit`, `miss`, `score`, `busy`, `done` all 0.

## Timing
- **Start:** `start` sampled at edge E0 → `busy`=1 from E0. SHOW entered at E0+`GAP_CYCLES` with `led` valid from that edge.
- **Press response:** a press present in the cycle before edge Ep → `hit`/`miss` high for exactly the cycle after Ep. At Ep, `led` goes to 0 and state goes to GAP/DONE.
- **Timeout:**
  - If SHOW is entered at edge S, `miss` is asserted at edge S+`WINDOW_CYCLES`.
  - A press in the final window cycle takes priority over the timeout.
- **Timeout-only game:** `done` rises at E0 + `ROUNDS`×(`GAP_CYCLES`+`WINDOW_CYCLES`). `busy` falls on the same edge.
- **Score latency:** `score` updates on the same edge that asserts `hit`.
- **DONE:** `score` holds until the next accepted `start`.

## Structure
- Package `reaction_pkg` holds:
  - state encoding constants;
  - LFSR width, tap positions and default seed;
  - the target-to-one-hot mapping function (2'b11→0).
- One sub-module, `btn_edge_detect` (3-bit): register plus AND-NOT, producing `press`.
- The FSM, timers, LFSR and scoring live in `reaction_round_ctrl`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-SHOW with `led`=3'b010 → all outputs 0 immediately. After release, the LFSR restarts at 7'h01 and `start` begins a fresh game.
- **Timeout-only game:** `ROUNDS`=2, `GAP_CYCLES`=4, `WINDOW_CYCLES`=8; `start` pulse, no buttons → `miss` pulses at E0+12 and E0+24. `done`=1 and `busy`=0 at E0+24, `score`=0.
- **Correct press:** press the lit button 3 cycles into SHOW → `hit` the following cycle, `score` 0→1, `led`=0, GAP entered.
- **Wrong press:** press a non-target button → `miss`, `score` unchanged. Press target plus another button in the same cycle → `miss`.
- **Held button:** target button held since before SHOW, never released → no hit; timeout `miss` at S+8.
- **Simultaneous events:**
  - Correct press in the last window cycle → `hit`, not `miss`.
  - `start` held during an active game → ignored; the round count is unaffected.
